intt_half_addsub: RTL
=====================

Name: intt_half_addsub

Overview:
- Gentleman-Sande INTT butterfly front end, the inverse-direction counterpart of the forward-NTT modular adder.
- Per beat, computes the halved modular sum (a+b)/2 mod q and the halved modular difference (a-b)/2 mod q. This folds the final n^-1 scaling into every INTT layer.
- Operates as either two independent 12-bit Kyber lanes (q=3329) or one 24-bit Dilithium lane (q=8380417).
- Two-stage elastic pipeline with valid/ready handshake. Sits between the coefficient RAM read port and the INTT twiddle multiplier.

Parameters:
- KQ, 3329, Kyber modulus.
- DQ, 8380417, Dilithium modulus.
- W, 24, datapath width (one 24-bit lane or two 12-bit lanes packed {hi,lo}).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_mode  input  1  0 = Kyber dual lane, 1 = Dilithium single lane.
- in_a  input  W  operand A; Kyber packs {A_hi[23:12], A_lo[11:0]}.
- in_b  input  W  operand B, same packing as in_a.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- out_mode  output  1  mode carried with the beat.
- out_sum  output  W  (a+b)*2^-1 mod q, per lane.
- out_diff  output  W  (a-b)*2^-1 mod q, per lane.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - out_valid=0, out_sum=0, out_diff=0, out_mode=0.
  - All stage registers and stage valid bits are cleared.
  - in_ready=1 from the first cycle after rst deasserts.
  - Any beats in flight are discarded; no partial output is produced.
- Handshake:
  - A beat transfers on in_valid & in_ready, and is delivered on out_valid & out_ready.
  - Once out_valid is high, out_* must hold stable until out_ready is high.
- Pipeline advance:
  - adv2 = ~v2 | out_ready.
  - adv1 = ~v1 | adv2.
  - in_ready = adv1 (combinational).
  - Full throughput is 1 beat/cycle. Latency is 2 cycles from input acceptance to out_valid when out_ready is held high.
- Stall behaviour: with out_ready low the pipeline holds at most 2 beats, then in_ready drops. Order is strictly preserved.
- Stage 1 (register s, d, mode, v1):
  - s = a+b; if s >= q then s -= q.
  - d = a-b; if the subtraction borrows then d += q.
  - Kyber: each 12-bit lane is computed with 13-bit intermediates; no carries cross lanes.
  - Dilithium: 25-bit intermediates.
- Stage 2 (register outputs): for each x in {s, d} and each lane:
  - if x is even, result = x>>1;
  - otherwise result = (x+q)>>1, using a 13- or 25-bit intermediate.
  - Results are always < q.
- Operands must be canonical (< q per lane). Non-canonical inputs produce an unspecified result and are not flagged.
- Mode is per beat. Mixed Kyber/Dilithium beats back-to-back are legal with no bubble.
- A simultaneous accept and deliver in the same cycle when both stages are full is legal; the pipeline shifts by one.

Decomposition:
- Shared package kd_mod_pkg holds KQ, DQ, the mode encoding (MODE_KYBER=0, MODE_DIL=1), and the lane widths (12 and 24). These are shared with the forward-NTT adder and the multipliers.
- One sub-module, mod_half, parameterised by width and q: given x < q, it returns x*2^-1 mod q, combinationally.
  - Stage 2 instantiates it 2x for Dilithium and 4x for Kyber.
  - The Dilithium instances and Kyber-hi instances may share logic via a mode mux.

Test Plan:
- Kyber, out_ready=1: a={3000,1}, b={1000,2} -> after 2 cycles out_sum={2000,1666}, out_diff={1000,1664}.
- Dilithium: a=8380416, b=2 -> out_sum=4190209, out_diff=4190207. Also a=0, b=0 -> out_sum=0, out_diff=0.
- Backpressure: out_ready=0, offer 3 beats -> 2 accepted, then in_ready=0. Raise out_ready -> 3 results out in order, third accepted on first free cycle.
- Back-to-back mixed modes for 16 cycles against a reference model -> 1 beat/cycle, out_mode tracks each beat, results match (x*2 mod q == a±b per lane).
- Assert rst mid-stream with 2 beats in flight -> out_valid=0 immediately, no stale beats after release, in_ready=1 after release.
- Random canonical operands, 10k beats, random out_ready -> every output < q and equals the model; no lane cross-talk in Kyber (hi lane at 3328+3328 with lo lane 0+0 -> lo results 0).

Source files
------------

// File: rtl/kd_mod_pkg.sv
// Shared Kyber/Dilithium modular constants.
// Used by the NTT/INTT adders and multipliers.
package kd_mod_pkg;

  localparam int KQ = 3329;
  localparam int DQ = 8380417;

  localparam int KW = 12;
  localparam int DW = 24;

  typedef enum logic {
    MODE_KYBER = 1'b0,
    MODE_DIL   = 1'b1
  } mode_e;

endpackage

// File: rtl/mod_half.sv
// Combinational x * 2^-1 mod q for canonical x.
// Odd x becomes even by adding q, then shifts.
module mod_half #(
  parameter int WIDTH = 12,
  parameter int Q     = 3329
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  localparam logic [WIDTH:0] QE = (WIDTH+1)'(Q);

  logic [WIDTH:0] t;
  logic           unused_lsb;

  // make x even (x or x+q), then halve
  always_comb begin
    t = {1'b0, x};
    if (x[0]) t = t + QE;
  end

  assign y          = t[WIDTH:1];
  assign unused_lsb = t[0];

endmodule

// File: rtl/intt_half_addsub.sv
// INTT Gentleman-Sande front end: halved
// modular sum/difference, two-stage elastic.
module intt_half_addsub
  import kd_mod_pkg::*;
#(
  parameter int W = DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_mode,
  output logic [W-1:0] out_sum,
  output logic [W-1:0] out_diff
);

  localparam logic [KW:0] KQE = (KW+1)'(KQ);
  localparam logic [DW:0] DQE = (DW+1)'(DQ);

  logic adv1, adv2;

  logic [KW:0] ks_lo, ks_hi, kd_lo, kd_hi;
  logic [DW:0] ds, dd;
  logic [W-1:0] s_in, d_in;

  logic         v1_q, v1_d;
  logic         m1_q, m1_d;
  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] d1_q, d1_d;

  logic         v2_q, v2_d;
  logic         m2_q, m2_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] diff_q, diff_d;

  logic [DW-1:0] dh_s, dh_d;
  logic [KW-1:0] kh_s_lo, kh_s_hi;
  logic [KW-1:0] kh_d_lo, kh_d_hi;

  logic unused_top;

  assign adv2     = ~v2_q | out_ready;
  assign adv1     = ~v1_q | adv2;
  assign in_ready = adv1;

  // per-lane modular add/sub with one
  // conditional correction each
  always_comb begin
    ks_lo = {1'b0, in_a[KW-1:0]}
          + {1'b0, in_b[KW-1:0]};
    if (ks_lo >= KQE) ks_lo = ks_lo - KQE;
    ks_hi = {1'b0, in_a[W-1:KW]}
          + {1'b0, in_b[W-1:KW]};
    if (ks_hi >= KQE) ks_hi = ks_hi - KQE;
    kd_lo = {1'b0, in_a[KW-1:0]}
          - {1'b0, in_b[KW-1:0]};
    if (kd_lo[KW]) kd_lo = kd_lo + KQE;
    kd_hi = {1'b0, in_a[W-1:KW]}
          - {1'b0, in_b[W-1:KW]};
    if (kd_hi[KW]) kd_hi = kd_hi + KQE;
    ds = {1'b0, in_a} + {1'b0, in_b};
    if (ds >= DQE) ds = ds - DQE;
    dd = {1'b0, in_a} - {1'b0, in_b};
    if (dd[DW]) dd = dd + DQE;
  end

  // select lane packing by beat mode
  always_comb begin
    s_in = {ks_hi[KW-1:0], ks_lo[KW-1:0]};
    d_in = {kd_hi[KW-1:0], kd_lo[KW-1:0]};
    if (in_mode == MODE_DIL) begin
      s_in = ds[DW-1:0];
      d_in = dd[DW-1:0];
    end
  end

  assign unused_top = ^{ks_lo[KW], ks_hi[KW],
                        kd_lo[KW], kd_hi[KW],
                        ds[DW], dd[DW]};

  mod_half #(.WIDTH(DW), .Q(DQ)) u_dh_s (
    .x(s1_q), .y(dh_s)
  );
  mod_half #(.WIDTH(DW), .Q(DQ)) u_dh_d (
    .x(d1_q), .y(dh_d)
  );
  mod_half #(.WIDTH(KW), .Q(KQ)) u_kh_s_lo (
    .x(s1_q[KW-1:0]), .y(kh_s_lo)
  );
  mod_half #(.WIDTH(KW), .Q(KQ)) u_kh_s_hi (
    .x(s1_q[W-1:KW]), .y(kh_s_hi)
  );
  mod_half #(.WIDTH(KW), .Q(KQ)) u_kh_d_lo (
    .x(d1_q[KW-1:0]), .y(kh_d_lo)
  );
  mod_half #(.WIDTH(KW), .Q(KQ)) u_kh_d_hi (
    .x(d1_q[W-1:KW]), .y(kh_d_hi)
  );

  // stage advance: load on free slot,
  // hold otherwise
  always_comb begin
    v1_d   = v1_q;
    m1_d   = m1_q;
    s1_d   = s1_q;
    d1_d   = d1_q;
    v2_d   = v2_q;
    m2_d   = m2_q;
    sum_d  = sum_q;
    diff_d = diff_q;
    if (adv1) begin
      v1_d = in_valid;
      if (in_valid) begin
        m1_d = in_mode;
        s1_d = s_in;
        d1_d = d_in;
      end
    end
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        m2_d = m1_q;
        if (m1_q == MODE_DIL) begin
          sum_d  = dh_s;
          diff_d = dh_d;
        end else begin
          sum_d  = {kh_s_hi, kh_s_lo};
          diff_d = {kh_d_hi, kh_d_lo};
        end
      end
    end
  end

  // pipeline registers, async clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      m1_q   <= 1'b0;
      s1_q   <= '0;
      d1_q   <= '0;
      v2_q   <= 1'b0;
      m2_q   <= 1'b0;
      sum_q  <= '0;
      diff_q <= '0;
    end else begin
      v1_q   <= v1_d;
      m1_q   <= m1_d;
      s1_q   <= s1_d;
      d1_q   <= d1_d;
      v2_q   <= v2_d;
      m2_q   <= m2_d;
      sum_q  <= sum_d;
      diff_q <= diff_d;
    end
  end

  assign out_valid = v2_q;
  assign out_mode  = m2_q;
  assign out_sum   = sum_q;
  assign out_diff  = diff_q;

endmodule
